asrm_mem_arbiter: RTL and testbench

Two-master arbiter that shares the single asrm system memory bus between the asrm CPU's RAM interface (master 0) and a second requester such as a DMA or debug port (master 1). It serialises accesses with a req/ack handshake and round-robin priority, drives the memory port for a fixed memory latency, and returns read data to the granted master. It sits between the masters and the RAM, replacing a direct CPU-to-RAM connection.

---
 rtl/asrm_mem_arbiter_pkg.sv | 22 ++
 rtl/asrm_mem_arbiter_if.sv | 31 +++
 rtl/asrm_mem_arbiter_rr_pick.sv | 17 +
 rtl/asrm_mem_arbiter.sv | 108 ++++++++++
 tb/tb_asrm_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/asrm_mem_arbiter_pkg.sv
// Shared types and constants for the asrm memory arbiter.
package asrm_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  localparam int ARB_LATENCY_MAX = 15;
  localparam int ARB_CNT_W       = 4;
  localparam int NUM_MASTERS     = 2;

  // Counter preload for a given memory latency; out-of-range latencies are
  // clamped to 1..ARB_LATENCY_MAX so the 4-bit counter can never wrap.
  function automatic logic [ARB_CNT_W-1:0] arb_cnt_load(input int lat);
    int l;
    l = (lat < 1) ? 1 : ((lat > ARB_LATENCY_MAX) ? ARB_LATENCY_MAX : lat);
    return ARB_CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/asrm_mem_arbiter_if.sv
// Bundle of both master handshakes and the shared memory port.
interface asrm_mem_arbiter_if #(parameter int wordsize = 16);

  logic                m0_req,   m1_req;
  logic                m0_we,    m1_we;
  logic [wordsize-1:0] m0_addr,  m1_addr;
  logic [wordsize-1:0] m0_wdata, m1_wdata;
  logic [wordsize-1:0] m0_rdata, m1_rdata;
  logic                m0_ack,   m1_ack;
  logic [wordsize-1:0] mem_addr;
  logic [wordsize-1:0] mem_wdata;
  logic                mem_we;
  logic [wordsize-1:0] mem_rdata;

  // Arbiter side: serves the masters, drives the RAM.
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_rdata, m1_rdata, m0_ack, m1_ack,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  // Environment side: the two requesters plus the RAM model.
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  m0_rdata, m1_rdata, m0_ack, m1_ack,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/asrm_mem_arbiter_rr_pick.sv
// Two-way round-robin selector: on a tie the master not granted last wins.
module asrm_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // Single request wins outright; a tie goes to the other master than last time.
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = req1;
    if (req0 && req1) grant_id = ~last_grant;
  end

endmodule

// File: rtl/asrm_mem_arbiter.sv
// Two-master arbiter for the asrm memory bus: serialises accesses, holds the
// RAM port for a fixed latency, returns read data and a one-cycle ack.
module asrm_mem_arbiter
  import asrm_mem_arbiter_pkg::*;
#(
  parameter int wordsize    = 16,
  parameter int mem_latency = 2
) (
  input  logic              clk,
  input  logic              reset,
  asrm_mem_arbiter_if.slave bus
);

  typedef struct packed {
    logic                we;
    logic [wordsize-1:0] addr;
    logic [wordsize-1:0] wdata;
  } arb_req_t;

  localparam logic [ARB_CNT_W-1:0] CNT_LOAD = arb_cnt_load(mem_latency);

  arb_state_e                                state, state_nxt;
  logic [ARB_CNT_W-1:0]                      cnt, cnt_nxt;
  logic                                      last_grant;
  logic                                      gid;
  logic                                      first;
  arb_req_t                                  lat;
  arb_req_t [NUM_MASTERS-1:0]                reqs;
  logic [NUM_MASTERS-1:0][wordsize-1:0]      rdata_q;
  logic                                      grant_valid, grant_id;
  logic                                      grant_take, capture;

  assign reqs[0] = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata};
  assign reqs[1] = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata};

  asrm_rr_pick u_pick (
    .req0        (bus.m0_req),
    .req1        (bus.m1_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign grant_take = (state == ARB_IDLE) && grant_valid;
  assign capture    = (state == ARB_ACCESS) && (cnt == '0);

  // State and latency counter registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ARB_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: grant from IDLE, count down ACCESS, single DONE cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_nxt = ARB_ACCESS;
          cnt_nxt   = CNT_LOAD;
        end
      end
      ARB_ACCESS: begin
        if (cnt == '0) state_nxt = ARB_DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ARB_DONE: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // Latch the granted request and capture read data at the end of ACCESS.
  // lat is only loaded on a grant, so the memory port holds its last value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat        <= '0;
      gid        <= 1'b0;
      first      <= 1'b0;
      last_grant <= 1'b1;
      rdata_q    <= '0;
    end else begin
      first <= grant_take;
      if (grant_take) begin
        lat        <= reqs[grant_id];
        gid        <= grant_id;
        last_grant <= grant_id;
      end
      if (capture && !lat.we) rdata_q[gid] <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr  = lat.addr;
  assign bus.mem_wdata = lat.wdata;
  // Write strobe only in the first ACCESS cycle so each write hits RAM once.
  assign bus.mem_we    = (state == ARB_ACCESS) && first && lat.we;

  assign bus.m0_rdata  = rdata_q[0];
  assign bus.m1_rdata  = rdata_q[1];
  assign bus.m0_ack    = (state == ARB_DONE) && !gid;
  assign bus.m1_ack    = (state == ARB_DONE) &&  gid;

endmodule

// File: tb/tb_asrm_mem_arbiter.sv
// Self-checking bench for asrm_mem_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level scheduling model.
module tb_asrm_mem_arbiter;

  localparam int W   = 16;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  asrm_mem_arbiter_if #(.wordsize(W)) bus0  ();
  asrm_mem_arbiter_if #(.wordsize(W)) bus1  ();
  asrm_mem_arbiter_if #(.wordsize(W)) bus15 ();

  asrm_mem_arbiter #(.wordsize(W), .mem_latency(LAT)) u_lat2 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  asrm_mem_arbiter #(.wordsize(W), .mem_latency(1)) u_lat1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  asrm_mem_arbiter #(.wordsize(W), .mem_latency(15)) u_lat15 (
    .clk(clk), .reset(reset), .bus(bus15.slave));

  // Initial RAM contents: address 0x10 holds 0xBEEF, others {a, ~a}.
  function automatic logic [W-1:0] mem_init(input int a);
    logic [7:0] b;
    b = a[7:0];
    if (a == 16) return 16'hBEEF;
    return {b, ~b};
  endfunction

  // RAM for the latency-2 instance; loaded on the first clock edge.
  logic [W-1:0] mem0 [256];
  logic         mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem0[i] <= mem_init(i);
      mem_ready <= 1'b1;
    end else if (bus0.mem_we) begin
      mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
    end
  end
  assign bus0.mem_rdata  = mem0[bus0.mem_addr[7:0]];
  assign bus1.mem_rdata  = bus1.mem_addr ^ 16'hA5A5;
  assign bus15.mem_rdata = bus15.mem_addr ^ 16'hA5A5;

  task automatic clr_inputs();
    bus0.m0_req = 0; bus0.m0_we = 0; bus0.m0_addr = '0; bus0.m0_wdata = '0;
    bus0.m1_req = 0; bus0.m1_we = 0; bus0.m1_addr = '0; bus0.m1_wdata = '0;
    bus1.m0_req = 0; bus1.m0_we = 0; bus1.m0_addr = '0; bus1.m0_wdata = '0;
    bus1.m1_req = 0; bus1.m1_we = 0; bus1.m1_addr = '0; bus1.m1_wdata = '0;
    bus15.m0_req = 0; bus15.m0_we = 0; bus15.m0_addr = '0; bus15.m0_wdata = '0;
    bus15.m1_req = 0; bus15.m1_we = 0; bus15.m1_addr = '0; bus15.m1_wdata = '0;
  endtask

  // Counts cycles until an ack on bus0 (bounded); who = 0, 1 or 2 (both).
  task automatic wait_ack0(output int cyc, output int who);
    cyc = -1;
    who = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus0.m0_ack || bus0.m1_ack) begin
        cyc = k;
        who = (bus0.m0_ack && bus0.m1_ack) ? 2 : (bus0.m1_ack ? 1 : 0);
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    bus0.m0_req = 1; bus0.m0_we = 1; bus0.m0_addr = 16'h0077; bus0.m0_wdata = 16'h5555;
    bus0.m1_req = 1;
    repeat (2) @(negedge clk);
    n_cmp += 9;
    if (bus0.m0_ack !== 1'b0)   begin n_bad++; $display("FAIL rst_m0_ack: got %b want 0", bus0.m0_ack); end
    if (bus0.m1_ack !== 1'b0)   begin n_bad++; $display("FAIL rst_m1_ack: got %b want 0", bus0.m1_ack); end
    if (bus0.mem_we !== 1'b0)   begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", bus0.mem_we); end
    if (bus0.mem_addr !== '0)   begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", bus0.mem_addr); end
    if (bus0.mem_wdata !== '0)  begin n_bad++; $display("FAIL rst_mem_wdata: got %h want 0", bus0.mem_wdata); end
    if (bus0.m0_rdata !== '0)   begin n_bad++; $display("FAIL rst_m0_rdata: got %h want 0", bus0.m0_rdata); end
    if (bus0.m1_rdata !== '0)   begin n_bad++; $display("FAIL rst_m1_rdata: got %h want 0", bus0.m1_rdata); end
    if (bus1.m0_ack !== 1'b0)   begin n_bad++; $display("FAIL rst_l1_ack: got %b want 0", bus1.m0_ack); end
    if (bus15.mem_we !== 1'b0)  begin n_bad++; $display("FAIL rst_l15_we: got %b want 0", bus15.mem_we); end
    clr_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus0.m0_we = 1'b0; bus0.m0_addr = 16'h0010; bus0.m0_wdata = '0; bus0.m0_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp += 3;
      if (bus0.m1_ack !== 1'b0) begin n_bad++; $display("FAIL rd_m1_ack: cyc %0d got %b want 0", k, bus0.m1_ack); end
      if (bus0.m0_ack !== 1'(k == 3)) begin n_bad++; $display("FAIL rd_m0_ack: cyc %0d got %b want %b", k, bus0.m0_ack, k == 3); end
      if (k <= 2) begin
        if (bus0.mem_addr !== 16'h0010) begin n_bad++; $display("FAIL rd_mem_addr: cyc %0d got %h want 0010", k, bus0.mem_addr); end
      end else if (bus0.m0_rdata !== 16'hBEEF) begin
        n_bad++; $display("FAIL rd_m0_rdata: cyc %0d got %h want beef", k, bus0.m0_rdata);
      end
      if (k == 3) bus0.m0_req = 1'b0;
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    bus0.m1_we = 1'b1; bus0.m1_addr = 16'h0042; bus0.m1_wdata = 16'h1234; bus0.m1_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp += 4;
      if (bus0.mem_we !== 1'(k == 1)) begin n_bad++; $display("FAIL wr_mem_we: cyc %0d got %b want %b", k, bus0.mem_we, k == 1); end
      if (bus0.m1_ack !== 1'(k == 3)) begin n_bad++; $display("FAIL wr_m1_ack: cyc %0d got %b want %b", k, bus0.m1_ack, k == 3); end
      if (bus0.m0_ack !== 1'b0) begin n_bad++; $display("FAIL wr_m0_ack: cyc %0d got %b want 0", k, bus0.m0_ack); end
      if (bus0.mem_addr !== 16'h0042) begin n_bad++; $display("FAIL wr_mem_addr: cyc %0d got %h want 0042", k, bus0.mem_addr); end
      if (k == 1) begin
        n_cmp++;
        if (bus0.mem_wdata !== 16'h1234) begin n_bad++; $display("FAIL wr_mem_wdata: got %h want 1234", bus0.mem_wdata); end
      end
      if (k >= 3) begin
        n_cmp++;
        if (bus0.m1_rdata !== '0) begin n_bad++; $display("FAIL wr_m1_rdata: cyc %0d got %h want 0", k, bus0.m1_rdata); end
      end
      if (k == 3) bus0.m1_req = 1'b0;
    end
  endtask

  task automatic test_contention();
    int cyc, who, exp_who;
    logic [W-1:0] got;
    clr_inputs();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    bus0.m0_addr = 16'h0020; bus0.m1_addr = 16'h0021;
    bus0.m0_req = 1'b1; bus0.m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack0(cyc, who);
      exp_who = i % 2;
      got = (who == 1) ? bus0.m1_rdata : bus0.m0_rdata;
      n_cmp += 3;
      if (who != exp_who) begin n_bad++; $display("FAIL rr_order: ack %0d got master %0d want %0d", i, who, exp_who); end
      if (cyc != ((i == 0) ? 3 : 4)) begin n_bad++; $display("FAIL rr_spacing: ack %0d got %0d want %0d", i, cyc, (i == 0) ? 3 : 4); end
      if (got !== mem_init(32 + exp_who)) begin n_bad++; $display("FAIL rr_rdata: ack %0d got %h want %h", i, got, mem_init(32 + exp_who)); end
    end
    clr_inputs();
  endtask

  task automatic test_back_to_back();
    int cyc, who;
    @(negedge clk);
    bus0.m0_addr = 16'h0030; bus0.m0_we = 1'b0; bus0.m0_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack0(cyc, who);
      n_cmp += 3;
      if (who != 0) begin n_bad++; $display("FAIL b2b_master: ack %0d got %0d want 0", i, who); end
      if (cyc != ((i == 0) ? 3 : 4)) begin n_bad++; $display("FAIL b2b_gap: ack %0d got %0d want %0d", i, cyc, (i == 0) ? 3 : 4); end
      if (bus0.m0_rdata !== mem_init(48)) begin n_bad++; $display("FAIL b2b_rdata: ack %0d got %h want %h", i, bus0.m0_rdata, mem_init(48)); end
    end
    clr_inputs();
  endtask

  task automatic test_reset_mid_access();
    int cyc, who;
    @(negedge clk);
    bus0.m1_we = 1'b1; bus0.m1_addr = 16'h0055; bus0.m1_wdata = 16'h7777; bus0.m1_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus0.mem_we !== 1'b1) begin n_bad++; $display("FAIL rma_first_we: got %b want 1", bus0.mem_we); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp += 7;
    if (bus0.mem_we !== 1'b0)  begin n_bad++; $display("FAIL rma_mem_we: got %b want 0", bus0.mem_we); end
    if (bus0.m1_ack !== 1'b0)  begin n_bad++; $display("FAIL rma_m1_ack: got %b want 0", bus0.m1_ack); end
    if (bus0.m0_ack !== 1'b0)  begin n_bad++; $display("FAIL rma_m0_ack: got %b want 0", bus0.m0_ack); end
    if (bus0.mem_addr !== '0)  begin n_bad++; $display("FAIL rma_mem_addr: got %h want 0", bus0.mem_addr); end
    if (bus0.mem_wdata !== '0) begin n_bad++; $display("FAIL rma_mem_wdata: got %h want 0", bus0.mem_wdata); end
    if (bus0.m0_rdata !== '0)  begin n_bad++; $display("FAIL rma_m0_rdata: got %h want 0", bus0.m0_rdata); end
    if (bus0.m1_rdata !== '0)  begin n_bad++; $display("FAIL rma_m1_rdata: got %h want 0", bus0.m1_rdata); end
    reset = 1'b1;
    wait_ack0(cyc, who);
    n_cmp += 2;
    if (cyc != 3) begin n_bad++; $display("FAIL rma_reserve_cyc: got %0d want 3", cyc); end
    if (who != 1) begin n_bad++; $display("FAIL rma_reserve_who: got %0d want 1", who); end
    clr_inputs();
  endtask

  task automatic test_latency_sweep();
    int t1, t15;
    logic [W-1:0] r1, r15;
    t1 = -1; t15 = -1; r1 = '0; r15 = '0;
    @(negedge clk);
    bus1.m0_we = 1'b0;  bus1.m0_addr = 16'h0003;  bus1.m0_req = 1'b1;
    bus15.m0_we = 1'b0; bus15.m0_addr = 16'h0003; bus15.m0_req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus1.m0_ack && t1 < 0) begin t1 = k; r1 = bus1.m0_rdata; bus1.m0_req = 1'b0; end
      if (bus15.m0_ack && t15 < 0) begin t15 = k; r15 = bus15.m0_rdata; bus15.m0_req = 1'b0; end
      if (t1 >= 0 && t15 >= 0) break;
    end
    n_cmp += 4;
    if (t1 != 2)            begin n_bad++; $display("FAIL lat1_ack: got %0d want 2", t1); end
    if (t15 != 16)          begin n_bad++; $display("FAIL lat15_ack: got %0d want 16", t15); end
    if (r1 !== 16'hA5A6)    begin n_bad++; $display("FAIL lat1_rdata: got %h want a5a6", r1); end
    if (r15 !== 16'hA5A6)   begin n_bad++; $display("FAIL lat15_rdata: got %h want a5a6", r15); end
    clr_inputs();
  endtask

  // Transaction-level model: arbiter free from idle_from; a grant in cycle c
  // completes with an ack in c+LAT+1 and frees the port at c+LAT+2.
  task automatic test_random();
    logic [W-1:0] model_mem [256];
    logic         rq [2];
    logic         rwe [2];
    logic [W-1:0] radr [2];
    logic [W-1:0] rwd [2];
    logic [W-1:0] exp_rd [2];
    logic         new_txn, a0, a1, g_we;
    logic [W-1:0] g_addr, g_wd;
    int           idle_from, ack_cyc, gm, last;
    int           stop;
    stop = 300;
    clr_inputs();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    model_mem = mem0;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0; rwe[i] = 1'b0; radr[i] = '0; rwd[i] = '0; exp_rd[i] = '0;
    end
    idle_from = 0; ack_cyc = -1; gm = 0; last = 1;
    g_we = 1'b0; g_addr = '0; g_wd = '0;
    for (int c = 0; c < stop + 40; c++) begin
      @(negedge clk);
      a0 = (c == ack_cyc) && (gm == 0);
      a1 = (c == ack_cyc) && (gm == 1);
      if (c == ack_cyc) begin
        if (g_we) model_mem[g_addr[7:0]] = g_wd;
        else      exp_rd[gm] = model_mem[g_addr[7:0]];
      end
      n_cmp += 4;
      if (bus0.m0_ack !== a0) begin n_bad++; $display("FAIL rnd_m0_ack: cyc %0d got %b want %b", c, bus0.m0_ack, a0); end
      if (bus0.m1_ack !== a1) begin n_bad++; $display("FAIL rnd_m1_ack: cyc %0d got %b want %b", c, bus0.m1_ack, a1); end
      if (bus0.m0_rdata !== exp_rd[0]) begin n_bad++; $display("FAIL rnd_m0_rdata: cyc %0d got %h want %h", c, bus0.m0_rdata, exp_rd[0]); end
      if (bus0.m1_rdata !== exp_rd[1]) begin n_bad++; $display("FAIL rnd_m1_rdata: cyc %0d got %h want %h", c, bus0.m1_rdata, exp_rd[1]); end
      for (int i = 0; i < 2; i++) begin
        new_txn = 1'b0;
        if (c == ack_cyc && gm == i) begin
          rq[i]   = (c < stop) && ($urandom_range(0, 1) == 1);
          new_txn = rq[i];
        end else if (!rq[i] && c < stop && $urandom_range(0, 2) == 0) begin
          rq[i]   = 1'b1;
          new_txn = 1'b1;
        end
        if (new_txn) begin
          rwe[i]  = ($urandom_range(0, 2) == 0);
          radr[i] = 16'($urandom_range(0, 31));
          rwd[i]  = 16'($urandom);
        end
      end
      if (c >= idle_from && (rq[0] || rq[1])) begin
        if (rq[0] && rq[1]) gm = (last == 1) ? 0 : 1;
        else                gm = rq[1] ? 1 : 0;
        last      = gm;
        g_we      = rwe[gm];
        g_addr    = radr[gm];
        g_wd      = rwd[gm];
        ack_cyc   = c + LAT + 1;
        idle_from = c + LAT + 2;
      end
      bus0.m0_req = rq[0]; bus0.m0_we = rwe[0]; bus0.m0_addr = radr[0]; bus0.m0_wdata = rwd[0];
      bus0.m1_req = rq[1]; bus0.m1_we = rwe[1]; bus0.m1_addr = radr[1]; bus0.m1_wdata = rwd[1];
    end
    clr_inputs();
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_reset_mid_access();
    test_latency_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish within 500000 time units, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
